// File: rtl/gate_pkg.sv
// Shared types and defaults for the gate interlock.
// Holds the FSM state enum, default timing constants and the command decoder.
package gate_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        H_ON  = 3'd1,
        L_ON  = 3'd2,
        DEAD  = 3'd3,
        FAULT = 3'd4
    } state_t;

    localparam int unsigned CLK_HZ            = 40_000_000;
    localparam int unsigned DEADTIME_CYC_DFLT = 40;
    localparam int unsigned MIN_ON_CYC_DFLT   = 8;
    localparam int unsigned FLT_FILT_CYC_DFLT = 4;
    localparam int unsigned CNT_W_DFLT        = 16;

    // Which ON state a clean command pair selects; conflicts and
    // a disarmed block both select IDLE.
    function automatic state_t pick_on(
        input logic cmd_h,
        input logic cmd_l,
        input logic enable
    );
        state_t res;
        res = IDLE;
        if (enable && cmd_h && !cmd_l) begin
            res = H_ON;
        end else if (enable && cmd_l && !cmd_h) begin
            res = L_ON;
        end
        return res;
    endfunction

endpackage

// File: rtl/fault_filter.sv
// Desaturation fault qualifier: 2-flop synchronizer plus consecutive-low filter.
// Ports: clk, rst_n, drv_fault_n (async, active-low) -> flt_qual, flt_active.
module fault_filter
    import gate_pkg::*;
#(
    parameter int unsigned FLT_FILT_CYC = FLT_FILT_CYC_DFLT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic drv_fault_n,
    output logic flt_qual,
    output logic flt_active
);

    localparam int unsigned FW = $clog2(FLT_FILT_CYC + 1);
    localparam logic [FW-1:0] LIMIT = FW'(FLT_FILT_CYC);

    logic [1:0]    sync_q;
    logic [FW-1:0] cnt;

    // Reset value is the inactive (no fault) level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], drv_fault_n};
        end
    end

    // Counts consecutive low synchronized samples; saturates at LIMIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (sync_q[1]) begin
            cnt <= '0;
        end else if (cnt != LIMIT) begin
            cnt <= cnt + FW'(1);
        end
    end

    assign flt_qual   = (cnt == LIMIT);
    assign flt_active = ~sync_q[1];

endmodule

// File: rtl/gate_interlock.sv
// Gate interlock: K1/K2 commands to gate drives with exclusion, dead time,
// minimum on-time and latched driver-fault shutdown.
// Ports: clk, rst_n, cmd_h, cmd_l, enable, drv_fault_n, fault_clr ->
//        gate_h, gate_l, fault_latched, illegal_cmd.
module gate_interlock
    import gate_pkg::*;
#(
    parameter int unsigned DEADTIME_CYC = DEADTIME_CYC_DFLT,
    parameter int unsigned MIN_ON_CYC   = MIN_ON_CYC_DFLT,
    parameter int unsigned FLT_FILT_CYC = FLT_FILT_CYC_DFLT,
    parameter int unsigned CNT_W        = CNT_W_DFLT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cmd_h,
    input  logic cmd_l,
    input  logic enable,
    input  logic drv_fault_n,
    input  logic fault_clr,
    output logic gate_h,
    output logic gate_l,
    output logic fault_latched,
    output logic illegal_cmd
);

    localparam logic [CNT_W-1:0] MIN_ON   = CNT_W'(MIN_ON_CYC);
    localparam logic [CNT_W-1:0] DEAD_LEN = CNT_W'(DEADTIME_CYC);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] on_cnt;
    logic [CNT_W-1:0] on_cnt_n;
    logic [CNT_W-1:0] dead_cnt;
    logic [CNT_W-1:0] dead_cnt_n;
    logic             illegal_n;

    logic flt_qual;
    logic flt_active;
    logic both;
    logic off_h;
    logic off_l;
    logic min_met;
    logic dead_done;
    logic clr_ok;
    logic [CNT_W-1:0] on_inc;
    logic [CNT_W-1:0] dead_inc;

    fault_filter #(
        .FLT_FILT_CYC(FLT_FILT_CYC)
    ) u_fault_filter (
        .clk        (clk),
        .rst_n      (rst_n),
        .drv_fault_n(drv_fault_n),
        .flt_qual   (flt_qual),
        .flt_active (flt_active)
    );

    assign both      = cmd_h & cmd_l;
    assign off_h     = ~cmd_h | cmd_l | ~enable;
    assign off_l     = ~cmd_l | cmd_h | ~enable;
    assign min_met   = (on_cnt >= MIN_ON);
    assign dead_done = (dead_cnt >= DEAD_LEN);
    // A still-qualified fault blocks the clear even if the pin has recovered.
    assign clr_ok    = fault_clr & ~flt_active & ~cmd_h & ~cmd_l & ~flt_qual;
    assign on_inc    = (on_cnt == '1) ? on_cnt : on_cnt + ONE;
    assign dead_inc  = (dead_cnt == '1) ? dead_cnt : dead_cnt + ONE;

    always_comb begin
        state_n    = state;
        on_cnt_n   = on_cnt;
        dead_cnt_n = dead_cnt;
        illegal_n  = illegal_cmd;

        unique case (state)
            IDLE: begin
                state_n  = pick_on(cmd_h, cmd_l, enable);
                on_cnt_n = ONE;
            end
            H_ON: begin
                on_cnt_n = on_inc;
                if (off_h && min_met) begin
                    state_n    = DEAD;
                    dead_cnt_n = ONE;
                end
            end
            L_ON: begin
                on_cnt_n = on_inc;
                if (off_l && min_met) begin
                    state_n    = DEAD;
                    dead_cnt_n = ONE;
                end
            end
            DEAD: begin
                // Last dead cycle may go straight into the next ON state.
                if (dead_done) begin
                    state_n  = pick_on(cmd_h, cmd_l, enable);
                    on_cnt_n = ONE;
                end else begin
                    dead_cnt_n = dead_inc;
                end
            end
            FAULT: begin
                if (clr_ok) begin
                    state_n   = IDLE;
                    illegal_n = 1'b0;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (both) begin
            illegal_n = 1'b1;
        end

        // A qualified fault overrides everything, including minimum on-time.
        if (flt_qual) begin
            state_n = FAULT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            on_cnt        <= '0;
            dead_cnt      <= '0;
            gate_h        <= 1'b0;
            gate_l        <= 1'b0;
            fault_latched <= 1'b0;
            illegal_cmd   <= 1'b0;
        end else begin
            state         <= state_n;
            on_cnt        <= on_cnt_n;
            dead_cnt      <= dead_cnt_n;
            gate_h        <= (state_n == H_ON);
            gate_l        <= (state_n == L_ON);
            fault_latched <= (state_n == FAULT);
            illegal_cmd   <= illegal_n;
        end
    end

endmodule

// File: tb/tb_gate_interlock.sv
// Self-checking bench for gate_interlock: vector table, directed sequences
// and randomized stimulus against a time-stamp based reference model.
module tb_gate_interlock;

    localparam int DT = 40;
    localparam int MO = 8;
    localparam int FF = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cmd_h = 1'b0;
    logic cmd_l = 1'b0;
    logic enable = 1'b0;
    logic drv_fault_n = 1'b1;
    logic fault_clr = 1'b0;
    logic gate_h;
    logic gate_l;
    logic fault_latched;
    logic illegal_cmd;

    gate_interlock dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_h        (cmd_h),
        .cmd_l        (cmd_l),
        .enable       (enable),
        .drv_fault_n  (drv_fault_n),
        .fault_clr    (fault_clr),
        .gate_h       (gate_h),
        .gate_l       (gate_l),
        .fault_latched(fault_latched),
        .illegal_cmd  (illegal_cmd)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference model: gate on/off times and a raw fault-sample history.
    int k;
    int on_g;
    int t_rise;
    int t_fall;
    bit m_flt;
    bit m_ill;
    bit fh_q[$];
    int run_q[$];
    int run_last;
    int p;
    bit qual;
    bit sact;
    logic pgh = 1'b0;
    logic pgl = 1'b0;
    int rise_h = 0;
    int fall_h = 0;
    int rise_l = 0;
    int fall_l = 0;

    task automatic model_reset();
        k = 0;
        on_g = 0;
        t_rise = 0;
        t_fall = -1000000;
        m_flt = 1'b0;
        m_ill = 1'b0;
        fh_q = {1'b1, 1'b1, 1'b1};
        run_q = {0, 0, 0};
        run_last = 0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (!rst_n) model_reset();
            check("scoreboard", {gate_h, gate_l, fault_latched, illegal_cmd},
                  {on_g == 1, on_g == 2, m_flt, m_ill});
            check("mutex", {31'd0, gate_h & gate_l}, 0);
            if (gate_h && !pgh) rise_h = cyc;
            if (!gate_h && pgh) fall_h = cyc;
            if (gate_l && !pgl) rise_l = cyc;
            if (!gate_l && pgl) fall_l = cyc;
            pgh = gate_h;
            pgl = gate_l;
            if (rst_n) begin
                // Predict the outputs after the coming rising edge.
                run_last = drv_fault_n ? 0 : run_last + 1;
                fh_q.push_back(drv_fault_n);
                run_q.push_back(run_last);
                p = fh_q.size() - 1;
                qual = (run_q[p-3] >= FF);
                sact = !fh_q[p-2];
                if (m_flt) begin
                    if (!qual && fault_clr && !sact && !cmd_h && !cmd_l) begin
                        m_flt = 1'b0;
                        m_ill = 1'b0;
                        t_fall = -1000000;
                    end
                end else if (on_g == 1) begin
                    if ((!cmd_h || cmd_l || !enable) && (k - t_rise >= MO)) begin
                        on_g = 0;
                        t_fall = k;
                    end
                end else if (on_g == 2) begin
                    if ((!cmd_l || cmd_h || !enable) && (k - t_rise >= MO)) begin
                        on_g = 0;
                        t_fall = k;
                    end
                end else if (k - t_fall >= DT) begin
                    if (enable && cmd_h && !cmd_l) begin
                        on_g = 1;
                        t_rise = k;
                    end else if (enable && cmd_l && !cmd_h) begin
                        on_g = 2;
                        t_rise = k;
                    end
                end
                if (cmd_h && cmd_l) m_ill = 1'b1;
                if (qual) begin
                    m_flt = 1'b1;
                    on_g = 0;
                end
                k++;
            end
        end
    end

    typedef struct {
        logic h;
        logic l;
        logic en;
        int   reps;
        logic eh;
        logic el;
        logic ei;
    } vec_t;

    vec_t tbl[16];
    int c0;
    int burst;
    int r;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1'b0, 1'b0, 1'b1, 1,   1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 3,   1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 1,   1'b1, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 6,   1'b1, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 1,   1'b1, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b1, 1,   1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 39,  1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 1,   1'b0, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 1,   1'b0, 1'b1, 1'b1};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 6,   1'b0, 1'b1, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1,   1'b0, 1'b0, 1'b1};
        tbl[11] = '{1'b1, 1'b0, 1'b1, 39,  1'b0, 1'b0, 1'b1};
        tbl[12] = '{1'b1, 1'b0, 1'b1, 1,   1'b1, 1'b0, 1'b1};
        tbl[13] = '{1'b1, 1'b0, 1'b1, 100, 1'b1, 1'b0, 1'b1};
        tbl[14] = '{1'b0, 1'b0, 1'b1, 1,   1'b0, 1'b0, 1'b1};
        tbl[15] = '{1'b0, 1'b0, 1'b1, 45,  1'b0, 1'b0, 1'b1};

        step(3);
        check("reset_outputs", {gate_h, gate_l, fault_latched, illegal_cmd}, 0);
        rst_n = 1'b1;
        enable = 1'b1;
        step(5);

        foreach (tbl[i]) begin
            cmd_h = tbl[i].h;
            cmd_l = tbl[i].l;
            enable = tbl[i].en;
            step(tbl[i].reps);
            check($sformatf("vec%0d", i),
                  {gate_h, gate_l, illegal_cmd, fault_latched},
                  {tbl[i].eh, tbl[i].el, tbl[i].ei, 1'b0});
        end
        enable = 1'b1;
        cmd_h = 1'b0;
        cmd_l = 1'b0;

        // Long high pulse followed by the low side.
        c0 = cyc;
        cmd_h = 1'b1;
        step(1200);
        cmd_h = 1'b0;
        step(40);
        cmd_l = 1'b1;
        step(20);
        cmd_l = 1'b0;
        step(60);
        check("long_rise_latency", rise_h - c0, 1);
        check("long_high_len", fall_h - rise_h, 1200);
        check("long_dead", rise_l - fall_h, DT);

        // Short pulse stretched to minimum on-time.
        cmd_h = 1'b1;
        step(2);
        cmd_h = 1'b0;
        cmd_l = 1'b1;
        step(60);
        cmd_l = 1'b0;
        step(60);
        check("short_high_len", fall_h - rise_h, MO);
        check("short_dead", rise_l - fall_h, DT);

        // Conflicting commands.
        cmd_h = 1'b1;
        cmd_l = 1'b1;
        step(3);
        check("both_cmd", {gate_h, gate_l, illegal_cmd}, 3'b001);
        cmd_h = 1'b0;
        cmd_l = 1'b0;
        step(50);

        // Fault glitch, then real fault.
        cmd_h = 1'b1;
        step(12);
        drv_fault_n = 1'b0;
        step(3);
        drv_fault_n = 1'b1;
        step(12);
        check("glitch_ignored", {gate_h, fault_latched}, 2'b10);
        drv_fault_n = 1'b0;
        c0 = cyc;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (!gate_h) break;
        end
        check("fault_latency_ok", {31'd0, (cyc - c0) <= 7}, 1);
        check("fault_latched", {gate_h, gate_l, fault_latched}, 3'b001);
        if (cyc - c0 < 10) step(10 - (cyc - c0));
        drv_fault_n = 1'b1;
        step(20);
        fault_clr = 1'b1;
        step(3);
        check("clr_blocked", {fault_latched, illegal_cmd, gate_h}, 3'b110);
        cmd_h = 1'b0;
        step(1);
        check("clr_exit", {fault_latched, illegal_cmd, gate_h, gate_l}, 0);
        fault_clr = 1'b0;
        cmd_h = 1'b1;
        step(1);
        check("after_clr_cmd", {gate_h, gate_l}, 2'b10);
        cmd_h = 1'b0;
        step(60);

        // Asynchronous reset in the middle of a low-side pulse.
        cmd_l = 1'b1;
        step(5);
        check("pre_reset_gl", {gate_h, gate_l}, 2'b01);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", {gate_h, gate_l, fault_latched, illegal_cmd}, 0);
        cmd_l = 1'b0;
        step(3);
        rst_n = 1'b1;
        step(5);
        check("post_reset_idle", {gate_h, gate_l}, 0);
        cmd_l = 1'b1;
        step(1);
        check("post_reset_cmd", {gate_h, gate_l}, 2'b01);
        cmd_l = 1'b0;
        step(60);

        // Randomized traffic checked by the model every cycle.
        burst = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 11) == 0) begin
                r = int'($urandom_range(0, 19));
                cmd_h = (r < 7) || (r == 19);
                cmd_l = (r >= 7 && r < 14) || (r == 19);
            end
            enable = ($urandom_range(0, 99) != 0);
            if (burst > 0) begin
                drv_fault_n = 1'b0;
                burst--;
            end else begin
                drv_fault_n = 1'b1;
                if ($urandom_range(0, 199) == 0) burst = int'($urandom_range(1, 12));
            end
            fault_clr = ($urandom_range(0, 7) == 0);
            step(1);
        end
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
